// File: rtl/vga_line_scaler.sv
// Doubles a 256-pixel NES line stream onto a 512x480 VGA active area using two
// ping-pong line buffers and a registered palette lookup (2 clk read latency).
module vga_line_scaler #(
  parameter int unsigned PIX_W = 6,
  parameter int unsigned RGB_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_sof,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  input  logic             pulse_25MHZ,
  input  logic             video_on,
  input  logic             h_sync,
  input  logic             v_sync,
  output logic [RGB_W-1:0] rgb,
  output logic             de,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             underrun,
  output logic             sof_err
);

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned PAL_N = 64;

  typedef enum logic [1:0] {ST_FREE = 2'd0, ST_READY = 2'd1, ST_SHOW = 2'd2} buf_st_e;

  localparam logic [11:0] PAL [PAL_N] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hB10, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

  logic [PIX_W-1:0] buf_mem [2][DEPTH];

  buf_st_e          st_q [2];
  buf_st_e          st_d [2];
  logic             wr_sel_q, wr_sel_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic             rd_sel_q, rd_sel_d;
  logic             show_sel_q, show_sel_d;
  logic             show_valid_q, show_valid_d;

  logic             wr_ready_q, wr_ready_d;
  logic             underrun_q, underrun_d;
  logic             sof_err_q, sof_err_d;
  logic             vid1_q, vid1_d, hs1_q, hs1_d, vs1_q, vs1_d, sv1_q, sv1_d;
  logic [PIX_W-1:0] rd_pix_q, rd_pix_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  logic             line_ev_c, rel_c, load_c, accept_c;
  logic [AW-1:0]    mem_addr_c;

  assign line_ev_c = pulse_25MHZ && (h_count == 10'd799);
  assign rel_c     = line_ev_c && v_count[0] && (v_count <= 10'd479);
  assign load_c    = line_ev_c && ((v_count[0] && (v_count < 10'd479)) || (v_count == 10'd524));
  assign accept_c  = wr_valid && wr_ready_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]      <= ST_FREE;
      st_q[1]      <= ST_FREE;
      wr_sel_q     <= 1'b0;
      wr_addr_q    <= '0;
      rd_sel_q     <= 1'b0;
      show_sel_q   <= 1'b0;
      show_valid_q <= 1'b0;
      wr_ready_q   <= 1'b0;
      underrun_q   <= 1'b0;
      sof_err_q    <= 1'b0;
      vid1_q       <= 1'b0;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      sv1_q        <= 1'b0;
      rgb_q        <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
    end else begin
      st_q         <= st_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      rd_sel_q     <= rd_sel_d;
      show_sel_q   <= show_sel_d;
      show_valid_q <= show_valid_d;
      wr_ready_q   <= wr_ready_d;
      underrun_q   <= underrun_d;
      sof_err_q    <= sof_err_d;
      vid1_q       <= vid1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      sv1_q        <= sv1_d;
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  // Buffer contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (accept_c) buf_mem[wr_sel_q][mem_addr_c] <= wr_data;
    rd_pix_q <= rd_pix_d;
  end

  // Next state: release, load and write all judged on registered buffer states
  always_comb begin
    st_d         = st_q;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    rd_sel_d     = rd_sel_q;
    show_sel_d   = show_sel_q;
    show_valid_d = show_valid_q;
    if (rel_c) begin
      for (int i = 0; i < 2; i++) begin
        if (st_q[i] == ST_SHOW) st_d[i] = ST_FREE;
      end
    end
    if (load_c) begin
      if (st_q[rd_sel_q] == ST_READY) begin
        st_d[rd_sel_q] = ST_SHOW;
        show_sel_d     = rd_sel_q;
        show_valid_d   = 1'b1;
        rd_sel_d       = ~rd_sel_q;
      end else begin
        show_valid_d   = 1'b0;
      end
    end
    if (accept_c) begin
      if (wr_sof) begin
        wr_addr_d = AW'(1);
      end else if (wr_addr_q == AW'(DEPTH - 1)) begin
        st_d[wr_sel_q] = ST_READY;
        wr_sel_d       = ~wr_sel_q;
        wr_addr_d      = '0;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
  end

  // Outputs and display pipeline
  always_comb begin
    wr_ready_d = (st_d[wr_sel_d] == ST_FREE);
    underrun_d = load_c && (st_q[rd_sel_q] != ST_READY);
    sof_err_d  = accept_c && wr_sof && (wr_addr_q != '0);
    mem_addr_c = wr_sof ? '0 : wr_addr_q;
    rd_pix_d   = buf_mem[show_sel_q][h_count[8:1]];
    vid1_d     = video_on;
    hs1_d      = h_sync;
    vs1_d      = v_sync;
    sv1_d      = show_valid_q;
    rgb_d      = (vid1_q && sv1_q) ? RGB_W'(PAL[6'(rd_pix_q)]) : '0;
    de_d       = vid1_q;
    hs_d       = hs1_q;
    vs_d       = vs1_q;
  end

  assign wr_ready = wr_ready_q;
  assign underrun = underrun_q;
  assign sof_err  = sof_err_q;
  assign rgb      = rgb_q;
  assign de       = de_q;
  assign vga_hs   = hs_q;
  assign vga_vs   = vs_q;

endmodule

// File: tb/tb_vga_line_scaler.sv
// Directed bench for vga_line_scaler: fill, display, underrun, sof restart,
// reset mid-line and back-pressure scenarios with hand-computed colours.
module tb_vga_line_scaler;

  localparam int unsigned PIX_W = 6;
  localparam int unsigned RGB_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [PIX_W-1:0] wr_data = '0;
  logic             wr_sof = 1'b0;
  logic [9:0]       h_count = '0;
  logic [9:0]       v_count = '0;
  logic             pulse_25MHZ = 1'b0;
  logic             video_on = 1'b0;
  logic             h_sync = 1'b0;
  logic             v_sync = 1'b0;
  logic [RGB_W-1:0] rgb;
  logic             de, vga_hs, vga_vs, underrun, sof_err;

  int checks = 0;
  int failures = 0;

  vga_line_scaler #(.PIX_W(PIX_W), .RGB_W(RGB_W)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_sof(wr_sof), .h_count(h_count), .v_count(v_count),
    .pulse_25MHZ(pulse_25MHZ), .video_on(video_on), .h_sync(h_sync),
    .v_sync(v_sync), .rgb(rgb), .de(de), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .underrun(underrun), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write beat, waiting a bounded time for wr_ready
  task automatic push(input logic [PIX_W-1:0] d, input logic sof);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sof   = sof;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!wr_ready) chk_eq("push_timeout", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic line_ev(input logic [9:0] v);
    video_on    = 1'b0;
    h_count     = 10'd799;
    v_count     = v;
    pulse_25MHZ = 1'b1;
    tick();
    pulse_25MHZ = 1'b0;
  endtask

  task automatic show(input logic [9:0] h, input logic [9:0] v, input logic vid);
    h_count  = h;
    v_count  = v;
    video_on = vid;
    tick();
    tick();
  endtask

  initial begin
    int acc;
    // Reset state, with live sync/video inputs that must not leak through
    h_sync = 1'b1; v_sync = 1'b1; video_on = 1'b1;
    repeat (3) tick();
    chk_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk_eq("rst_rgb", 32'(rgb), 32'h0);
    chk_eq("rst_de", 32'(de), 32'd0);
    chk_eq("rst_hs_vs", 32'({vga_hs, vga_vs}), 32'd0);
    chk_eq("rst_events", 32'({underrun, sof_err}), 32'd0);
    h_sync = 1'b0; v_sync = 1'b0; video_on = 1'b0;
    rst = 1'b0;
    tick();
    chk_eq("rel_wr_ready", 32'(wr_ready), 32'd1);

    // Fill B0 with 0x30 (sof on first beat is legal), load at v=524
    push(6'h30, 1'b1);
    chk_eq("sof_at0_noerr", 32'(sof_err), 32'd0);
    for (int k = 1; k < 256; k++) push(6'h30, 1'b0);
    line_ev(10'd524);
    chk_eq("load524_no_underrun", 32'(underrun), 32'd0);
    show(10'd0, 10'd0, 1'b1);
    chk_eq("v0_h0_rgb", 32'(rgb), 32'hFFF);
    chk_eq("v0_h0_de", 32'(de), 32'd1);
    show(10'd511, 10'd1, 1'b1);
    chk_eq("v1_h511_rgb", 32'(rgb), 32'hFFF);
    show(10'd512, 10'd1, 1'b0);
    chk_eq("h512_rgb", 32'(rgb), 32'h0);
    chk_eq("h512_de", 32'(de), 32'd0);
    h_sync = 1'b1; v_sync = 1'b1;
    tick();
    chk_eq("sync_lat1", 32'({vga_hs, vga_vs}), 32'd0);
    tick();
    chk_eq("sync_lat2", 32'({vga_hs, vga_vs}), 32'b11);
    h_sync = 1'b0; v_sync = 1'b0;

    // Pixel k = k%64 into B1, shown on v=2 after the v=1 swap
    for (int k = 0; k < 256; k++) push(6'(k % 64), 1'b0);
    chk_eq("both_busy_ready", 32'(wr_ready), 32'd0);
    line_ev(10'd1);
    chk_eq("load1_no_underrun", 32'(underrun), 32'd0);
    show(10'd30, 10'd2, 1'b1);
    chk_eq("k15_rgb", 32'(rgb), 32'h000);
    h_count = 10'd44;
    tick();
    chk_eq("k22_lat1", 32'(rgb), 32'h000);
    tick();
    chk_eq("k22_lat2", 32'(rgb), 32'hB10);
    show(10'd45, 10'd2, 1'b1);
    chk_eq("k22_odd_h", 32'(rgb), 32'hB10);
    show(10'd96, 10'd3, 1'b1);
    chk_eq("k48_rgb", 32'(rgb), 32'hFFF);
    show(10'd225, 10'd3, 1'b1);
    chk_eq("k112_rgb", 32'(rgb), 32'hFFF);
    show(10'd428, 10'd3, 1'b1);
    chk_eq("k214_rgb", 32'(rgb), 32'hB10);

    // No READY line at v=3: underrun, blank lines, then recovery
    line_ev(10'd3);
    chk_eq("underrun_pulse", 32'(underrun), 32'd1);
    tick();
    chk_eq("underrun_clear", 32'(underrun), 32'd0);
    show(10'd44, 10'd4, 1'b1);
    chk_eq("underrun_rgb", 32'(rgb), 32'h0);
    chk_eq("underrun_de", 32'(de), 32'd1);
    for (int k = 0; k < 256; k++) push(6'h16, 1'b0);
    line_ev(10'd5);
    chk_eq("recover_no_underrun", 32'(underrun), 32'd0);
    show(10'd10, 10'd6, 1'b1);
    chk_eq("recover_rgb", 32'(rgb), 32'hB10);

    // sof at wr_addr=100 restarts the line in B1
    for (int k = 0; k < 100; k++) push(6'h0F, 1'b0);
    push(6'h30, 1'b1);
    chk_eq("sof_err_pulse", 32'(sof_err), 32'd1);
    tick();
    chk_eq("sof_err_clear", 32'(sof_err), 32'd0);
    for (int k = 0; k < 254; k++) push(6'h30, 1'b0);
    chk_eq("sof_254_not_done", 32'(wr_ready), 32'd1);
    push(6'h30, 1'b0);
    chk_eq("sof_255_done", 32'(wr_ready), 32'd0);
    line_ev(10'd7);
    chk_eq("sof_load_ok", 32'(underrun), 32'd0);
    show(10'd100, 10'd8, 1'b1);
    chk_eq("sof_line_rgb", 32'(rgb), 32'hFFF);

    // Reset in the middle of a displayed line
    h_sync = 1'b1; v_sync = 1'b1;
    show(10'd300, 10'd200, 1'b1);
    chk_eq("pre_rst_rgb", 32'(rgb), 32'hFFF);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_outs", 32'({rgb, de, vga_hs, vga_vs, underrun, sof_err, wr_ready}), 32'h0);
    tick();
    h_sync = 1'b0; v_sync = 1'b0;
    rst = 1'b0;
    tick();
    chk_eq("post_rst_ready", 32'(wr_ready), 32'd1);
    line_ev(10'd201);
    chk_eq("post_rst_underrun", 32'(underrun), 32'd1);
    show(10'd300, 10'd202, 1'b1);
    chk_eq("post_rst_rgb", 32'(rgb), 32'h0);

    // Hold wr_valid: exactly 512 beats fit, then back-pressure
    acc = 0;
    for (int i = 0; i < 530; i++) begin
      wr_valid = 1'b1;
      wr_data  = (acc < 256) ? 6'h16 : 6'h30;
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    chk_eq("hold_accepted", 32'(acc), 32'd512);
    chk_eq("hold_ready_low", 32'(wr_ready), 32'd0);
    line_ev(10'd524);
    chk_eq("hold_load0", 32'(underrun), 32'd0);
    show(10'd0, 10'd0, 1'b1);
    chk_eq("hold_b0_rgb", 32'(rgb), 32'hB10);
    line_ev(10'd1);
    chk_eq("hold_load1", 32'(underrun), 32'd0);
    chk_eq("hold_ready_back", 32'(wr_ready), 32'd1);
    show(10'd0, 10'd2, 1'b1);
    chk_eq("hold_b1_rgb", 32'(rgb), 32'hFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_line_scaler.md
VGA_LINE_SCALER -- requirements
Module: vga_line_scaler

Interface
REQ-001 Parameter PIX_W, default 6, SHALL be the NES palette-index width.
REQ-002 Parameter RGB_W, default 12, SHALL be the output colour width, 4:4:4 R[11:8] G[7:4] B[3:0].
REQ-003 Ports: clk  in  1  system clock; single clock domain.
REQ-004 Ports: rst  in  1  asynchronous, active-high reset.
REQ-005 Ports: wr_valid, wr_ready, wr_data, wr_sof  in/out/in/in  1/1/PIX_W/1  PPU pixel stream; wr_sof marks the frame's first pixel.
REQ-006 Ports: h_count, v_count  in  10/10  VGA timing counters: 800x525 frame, 512x480 active area.
REQ-007 Ports: pulse_25MHZ, video_on, h_sync, v_sync  in  1 each  pixel enable, active-area flag, raw syncs.
REQ-008 Ports: rgb, de, vga_hs, vga_vs  out  RGB_W/1/1/1  pixel colour, delayed video_on, delayed syncs.
REQ-009 Ports: underrun, sof_err  out  1/1  one-clk event pulses.

Function
REQ-010 Two 256 x PIX_W line buffers (B0, B1); each SHALL hold state FREE, READY or SHOW.
REQ-011 Write pointer wr_sel (1b) and wr_addr (8b); wr_ready SHALL equal (state[wr_sel]==FREE) while rst is low.
REQ-012 A beat is accepted when wr_valid && wr_ready; wr_data is written to buf[wr_sel][wr_addr]; wr_addr then increments.
REQ-013 When the beat at wr_addr==255 is accepted: state[wr_sel] becomes READY, wr_sel toggles, wr_addr wraps to 0.
REQ-014 An accepted beat with wr_sof=1 SHALL write at address 0 and set wr_addr to 1.
REQ-015 If wr_addr!=0 on that beat, sof_err SHALL pulse and the partial line SHALL be discarded.
REQ-016 wr_sof on an unaccepted cycle SHALL be ignored.
REQ-017 Line event: pulse_25MHZ && h_count==799, tagged by v_count.
REQ-018 Release: on a line event with v_count odd and <=479, the SHOW buffer (if any) SHALL become FREE.
REQ-019 Load: on a line event with v_count odd and <479, or with v_count==524:
  - if state[rd_sel]==READY, that buffer SHALL become SHOW, show_valid SHALL be set to 1 and rd_sel SHALL toggle;
  - otherwise show_valid SHALL be set to 0 and underrun SHALL pulse for one clk.
REQ-020 Release and load in the same cycle SHALL both take effect; states are evaluated on registered values.
REQ-021 A buffer completing in the same cycle as a load is not yet READY, so underrun applies.
REQ-022 Each NES line SHALL therefore display on VGA lines 2n and 2n+1; line n=0 is loaded at v_count==524.
REQ-023 Read address SHALL be h_count[8:1], so each pixel is shown for 2 pixel clocks; the read SHALL be taken from the SHOW buffer.
REQ-024 Pipeline:
  - stage 1: registered buffer read;
  - stage 2: registered 64-entry palette ROM lookup to rgb.
REQ-025 Total latency is 2 clk from h_count/v_count; this is less than one 4-clk pixel period.
REQ-026 video_on, h_sync and v_sync SHALL be delayed by the same 2 clk to produce de, vga_hs and vga_vs; sync polarity SHALL be unchanged.
REQ-027 rgb SHALL be 0 whenever delayed video_on==0 or delayed show_valid==0.
REQ-028 Palette ROM: entry 0x30 = 0xFFF, 0x0F = 0x000, 0x16 = 0xB10; all other entries per the team NES palette table.
REQ-029 Writes and reads SHALL target different buffers at all times; no bypass path is needed.

Reset
REQ-030 While rst is high:
  - both buffers FREE; wr_sel=0, rd_sel=0, wr_addr=0, show_valid=0;
  - rgb=0, de=0, vga_hs=0, vga_vs=0, underrun=0, sof_err=0, wr_ready=0.
REQ-031 Buffer contents SHALL NOT be reset.
REQ-032 On the first clk after rst deasserts, wr_ready=1.
REQ-033 Reset mid-line SHALL discard any partial write and any displayed line; the first load after reset underruns unless a full line has been written.

Verification
REQ-034 Fill B0 with 256 x 0x30, then hit the v=524 line event -> B0 becomes SHOW; v_count 0-1, h_count 0-511 give rgb=0xFFF, de=1; rgb=0 at h>=512.
REQ-035 Write pixel k = k%64 -> at h_count=2k and 2k+1, rgb = palette[k%64], 2 clk after h_count changes.
REQ-036 Hold wr_valid=1 with no line events, write 512 beats -> both buffers READY, wr_ready=0 on the next beat, no further writes accepted.
REQ-037 Line event at v=1 with no READY buffer -> underrun pulses 1 clk; rgb=0 for v_count 2-3; recovery on the next load once a line is READY.
REQ-038 wr_sof asserted at wr_addr=100 -> sof_err pulses; wr_addr=1 after the beat; the buffer becomes READY only after 255 more beats.
REQ-039 Assert rst mid-line at h=300, v=200 -> all outputs 0 during reset; wr_ready=1 the clk after release; the next load underruns.
